// File: rtl/load_store_unit.sv
// Load/store unit between the ALU and a word-wide data memory with a req/ack handshake.
// It aligns bytes, sets byte enables, extends loads, and reports faults and bus timeouts.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic        op_store,
  input  logic [2:0]  op_funct3,
  input  logic [31:0] op_addr,
  input  logic [31:0] op_wdata,
  input  logic [4:0]  op_rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        stall,
  output logic        exc_valid,
  output logic [1:0]  exc_cause
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP, EXC} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              accept, fault, timeout_hit;
  logic [1:0]        fault_cause;

  logic              store_p0;
  logic [2:0]        funct3_p0;
  logic [31:0]       addr_p0;
  logic [31:0]       wdata_p0;
  logic [4:0]        rd_p0;
  logic [1:0]        cause_p0;
  logic [31:0]       ld_data_p1;

  function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 4'b0001 << a;
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [1:0] a,
                                              input logic [31:0] rdata);
    logic        [31:0] lane;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] sx;
    lane = rdata >> {a, 3'b000};
    b    = lane[7:0];
    h    = lane[15:0];
    case (f3)
      3'b000:  sx = 32'(b);
      3'b001:  sx = 32'(h);
      3'b100:  sx = {24'd0, lane[7:0]};
      3'b101:  sx = {16'd0, lane[15:0]};
      default: sx = lane;
    endcase
    return $unsigned(sx);
  endfunction

  assign op_ready    = (state == IDLE);
  assign accept      = op_valid && op_ready;
  assign timeout_hit = (cnt == CNT_LAST);

  // Illegal encodings take priority over misalignment.
  always_comb begin
    fault       = 1'b0;
    fault_cause = 2'b00;
    if (op_funct3 inside {3'b011, 3'b110, 3'b111} || (op_store && op_funct3[2])) begin
      fault       = 1'b1;
      fault_cause = 2'b00;
    end else if ((op_funct3[1:0] == 2'b01 && op_addr[0]) ||
                 (op_funct3[1:0] == 2'b10 && op_addr[1:0] != 2'b00)) begin
      fault       = 1'b1;
      fault_cause = op_store ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          cnt_nxt   = '0;
          state_nxt = fault ? EXC : ACCESS;
        end
      end
      ACCESS: begin
        if (mem_ack)          state_nxt = RESP;
        else if (timeout_hit) state_nxt = EXC;
        else                  cnt_nxt   = cnt + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // p0: op latched at accept; p1: extended load lane captured on ack.
  always_ff @(posedge clk) begin
    if (accept) begin
      store_p0  <= op_store;
      funct3_p0 <= op_funct3;
      addr_p0   <= op_addr;
      wdata_p0  <= op_wdata;
      rd_p0     <= op_rd;
    end
    if (accept && fault)
      cause_p0 <= fault_cause;
    else if (state == ACCESS && !mem_ack && timeout_hit)
      cause_p0 <= 2'b11;
    if (state == ACCESS && mem_ack)
      ld_data_p1 <= extend_load(funct3_p0, addr_p0[1:0], mem_rdata);
  end

  // Data-carrying outputs are gated by state so they read zero outside their window.
  assign mem_req   = (state == ACCESS);
  assign mem_we    = mem_req && store_p0;
  assign mem_addr  = mem_req ? {addr_p0[31:2], 2'b00} : 32'd0;
  assign mem_be    = mem_req ? lane_be(funct3_p0, addr_p0[1:0]) : 4'd0;
  assign mem_wdata = mem_req ? lane_wdata(funct3_p0, wdata_p0) : 32'd0;

  assign wb_valid  = (state == RESP) && !store_p0 && (rd_p0 != 5'd0);
  assign wb_rd     = wb_valid ? rd_p0 : 5'd0;
  assign wb_data   = wb_valid ? ld_data_p1 : 32'd0;

  assign exc_valid = (state == EXC);
  assign exc_cause = exc_valid ? cause_p0 : 2'b00;

  assign stall     = ((state == IDLE) && op_valid) || (state == ACCESS);

endmodule
